usb_out_arbiter: RTL
====================

USB_OUT_ARBITER -- requirements
Module: usb_out_arbiter

Interface
REQ-001 Parameter BURST, default 256: maximum 32-bit words sent per grant; legal range 1..65535.
REQ-002 ifclk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 enable  in  1  1 allows new grants and word accepts; 0 stops them.
REQ-005 req0_data  in  32  requester 0 word; low half is sent first.
REQ-006 req0_valid  in  1  requester 0 has a word available.
REQ-007 req0_ready  out  1  requester 0 word is consumed at this edge (pop strobe).
REQ-008 req1_data / req1_valid / req1_ready  in 32 / in 1 / out 1  requester 1, same semantics as REQ-005..007.
REQ-009 usb_di  out  16  half-word toward the EZ-USB output path.
REQ-010 usb_di_valid  out  1  usb_di is valid.
REQ-011 usb_di_ready  in  1  sink accepts usb_di at this edge.
REQ-012 grant  out  2  one-hot owner of the output path; 2'b00 when idle.
REQ-013 busy  out  1  1 in any state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, LO and HI.
REQ-015 IDLE: if enable and any reqN_valid, set grant to the winner per REQ-022, clear word_cnt and go to GRANT; otherwise stay.
REQ-016 GRANT: if granted valid, assert granted req_ready combinationally, capture data into buf, increment word_cnt and go to LO; if granted valid is 0, release per REQ-020.
REQ-017 LO: usb_di = buf[15:0] and usb_di_valid = 1; on usb_di_ready go to HI, otherwise hold usb_di and usb_di_valid stable.
REQ-018 HI: usb_di = buf[31:16] and usb_di_valid = 1; on usb_di_ready apply REQ-019; otherwise hold.
REQ-019 HI with usb_di_ready:
- release if word_cnt == BURST or enable = 0;
- otherwise, if granted valid is 1, assert req_ready in the same cycle, capture the new word, increment word_cnt and go to LO (back-to-back);
- otherwise release.
REQ-020 Release SHALL set grant to 00, record the released requester as last_served and go to IDLE.
REQ-021 req_ready SHALL be asserted only for the granted requester, only in GRANT or HI per REQ-016/019, and only when that requester's valid is 1.
REQ-022 Round-robin: if one requester is valid, it wins; if both are valid in the same cycle, the requester not equal to last_served wins.
REQ-023 Sustained throughput SHALL be one half-word per cycle while usb_di_ready = 1 and the source stays valid; there is one GRANT bubble cycle per grant.
REQ-024 usb_di SHALL be 16'h0000 in IDLE and GRANT.
REQ-025 Word order SHALL be preserved per requester; no word is dropped or duplicated except on reset.
REQ-026 Dropping enable mid-word SHALL still complete both halves of buf.
REQ-027 word_cnt SHALL be 16 bits and saturate conceptually at BURST; it never wraps within a grant.
REQ-028 BURST = 1 SHALL alternate grants word-by-word when both requesters are continuously valid.

Reset
REQ-029 While reset_n = 0: state = IDLE, grant = 00, usb_di = 0, usb_di_valid = 0, req0_ready = req1_ready = 0, busy = 0, word_cnt = 0, buf = 0, last_served = 1 (requester 0 wins first).
REQ-030 Reset mid-word SHALL discard the partially sent word.
REQ-031 The first grant SHALL be possible in the first cycle after reset_n rises.

Structure
REQ-032 Shared package usb_arb_pkg SHALL hold the state encoding, the BURST default and the word_cnt width constant.
REQ-033 A sub-module rr_arb2 SHALL implement the 2-way round-robin pick: inputs valid[1:0] and last_served; output winner one-hot.
REQ-034 buf, the FSM and word_cnt SHALL live in usb_out_arbiter; no FIFOs are inside the block.

Verification
REQ-035 Only req0 valid, data 32'h05040302, usb_di_ready = 1 -> grant = 01; usb_di 16'h0302 then 16'h0504; req0_ready pulses once.
REQ-036 Both valid at reset release, BURST = 2, sink always ready -> two req0 words, then two req1 words, then req0 again; grant never 11.
REQ-037 usb_di_ready held 0 for 5 cycles during LO -> usb_di and usb_di_valid stable; no req_ready pulse.
REQ-038 enable dropped during HI of word 3 of a BURST = 256 stream -> word 3 completes, grant 00, no further req_ready.
REQ-039 reset_n asserted during LO -> all outputs 0 asynchronously; after release, req0 is granted first.

Source files
------------

// File: rtl/usb_arb_pkg.sv
// Shared constants for the USB OUT arbiter: FSM state encoding, the default
// burst length and the per-grant word counter width.
package usb_arb_pkg;

  localparam int unsigned BURST_DEFAULT = 256;
  localparam int unsigned WCNT_W        = 16;

  typedef logic [WCNT_W-1:0] wcnt_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_LO    = 2'd2;
  localparam logic [1:0] ST_HI    = 2'd3;

endpackage

// File: rtl/usb_out_arbiter_if.sv
// Bus bundle between two 32-bit word sources, the arbiter and the 16-bit
// EZ-USB output path.
//   req0_*/req1_* : source words (valid from source, ready = pop strobe)
//   usb_di*       : half-word stream toward the sink
//   grant, busy   : arbiter status
// slave  : arbiter side
// master : environment side (sources, sink, status observer)
interface usb_out_arbiter_if;
  logic [31:0] req0_data;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req1_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] usb_di;
  logic        usb_di_valid;
  logic        usb_di_ready;
  logic [1:0]  grant;
  logic        busy;

  modport slave (
    input  req0_data, req0_valid, req1_data, req1_valid, usb_di_ready,
    output req0_ready, req1_ready, usb_di, usb_di_valid, grant, busy
  );

  modport master (
    output req0_data, req0_valid, req1_data, req1_valid, usb_di_ready,
    input  req0_ready, req1_ready, usb_di, usb_di_valid, grant, busy
  );
endinterface

// File: rtl/usb_out_arbiter_rr_arb2.sv
// Two-way round-robin pick.
//   valid_i       : per-requester valid
//   last_served_i : requester released most recently (0 or 1)
//   winner_o      : one-hot winner, 2'b00 when nothing is valid
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_served_i,
  output logic [1:0] winner_o
);

  always_comb begin
    winner_o = 2'b00;
    case (valid_i)
      2'b01:   winner_o = 2'b01;
      2'b10:   winner_o = 2'b10;
      // contention: whoever was not served last goes next
      2'b11:   winner_o = last_served_i ? 2'b01 : 2'b10;
      default: winner_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/usb_out_arbiter.sv
// Arbitrates two 32-bit word sources onto a 16-bit USB output path, low
// half first. A grant lasts up to BURST words, back-to-back while the
// owner stays valid and the sink keeps accepting.
//   ifclk, reset_n : clock, async active-low reset
//   enable         : gates new grants and word accepts
//   bus            : usb_out_arbiter_if.slave (sources, sink, status)
module usb_out_arbiter
  import usb_arb_pkg::*;
#(
  parameter int unsigned BURST = BURST_DEFAULT
) (
  input  logic               ifclk,
  input  logic               reset_n,
  input  logic               enable,
  usb_out_arbiter_if.slave   bus
);

  localparam wcnt_t BURST_C = wcnt_t'(BURST);

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [31:0] buf_q, buf_d;
  wcnt_t       wcnt_q, wcnt_d;
  logic        last_q, last_d;

  logic [1:0]  winner;
  logic        gvalid;
  logic [31:0] gdata;
  logic        take;
  logic        rel;

  rr_arb2 u_rr (
    .valid_i       ({bus.req1_valid, bus.req0_valid}),
    .last_served_i (last_q),
    .winner_o      (winner)
  );

  assign gvalid = (grant_q[0] & bus.req0_valid) | (grant_q[1] & bus.req1_valid);
  assign gdata  = grant_q[1] ? bus.req1_data : bus.req0_data;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    buf_d   = buf_q;
    wcnt_d  = wcnt_q;
    last_d  = last_q;
    take    = 1'b0;
    rel     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && (|winner)) begin
          grant_d = winner;
          wcnt_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (enable && gvalid) take = 1'b1;
        else                  rel  = 1'b1;
      end
      ST_LO: begin
        if (bus.usb_di_ready) state_d = ST_HI;
      end
      ST_HI: begin
        // the high half always completes; enable only blocks the next word
        if (bus.usb_di_ready) begin
          if (wcnt_q == BURST_C || !enable || !gvalid) rel  = 1'b1;
          else                                         take = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      buf_d   = gdata;
      wcnt_d  = wcnt_q + wcnt_t'(1);
      state_d = ST_LO;
    end
    if (rel) begin
      grant_d = 2'b00;
      last_d  = grant_q[1];
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      buf_q   <= '0;
      wcnt_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      buf_q   <= buf_d;
      wcnt_q  <= wcnt_d;
      last_q  <= last_d;
    end
  end

  // outputs decode straight from state so reset clears them at once
  assign bus.req0_ready   = take & grant_q[0];
  assign bus.req1_ready   = take & grant_q[1];
  assign bus.usb_di_valid = (state_q == ST_LO) || (state_q == ST_HI);
  assign bus.usb_di       = (state_q == ST_LO) ? buf_q[15:0]  :
                            (state_q == ST_HI) ? buf_q[31:16] : 16'h0000;
  assign bus.grant        = grant_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule
